// File: rtl/ysyx_23060236_icache_sa_pkg.sv
// Shared constants, derived-size helpers and FSM encoding for the
// set-associative instruction cache.
package ysyx_23060236_icache_sa_pkg;

  localparam int ADDR_LEN_DEF   = 25;
  localparam int DATA_LEN_DEF   = 32;
  localparam int OFFSET_LEN_DEF = 5;
  localparam int INDEX_LEN_DEF  = 2;
  localparam int WAYS_DEF       = 2;

  function automatic int line_words(input int offset_len);
    return 1 << (offset_len - 2);
  endfunction

  // Keeps way-select vectors at least one bit wide for the direct-mapped case.
  function automatic int way_bits(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  localparam int LINE_WORDS = line_words(OFFSET_LEN_DEF);
  localparam int WAY_BITS   = way_bits(WAYS_DEF);

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_RESP
  } state_e;

endpackage

// File: rtl/ysyx_23060236_icache_sa_if.sv
// Fetch-side request/response bus and memory-side burst read bus.
// The cache is the slave of the fetch bus and the master of the memory bus.
interface ysyx_23060236_icache_fetch_if #(
  parameter int ADDR_LEN = ysyx_23060236_icache_sa_pkg::ADDR_LEN_DEF,
  parameter int DATA_LEN = ysyx_23060236_icache_sa_pkg::DATA_LEN_DEF
);
  logic                req_valid;
  logic                req_ready;
  logic [ADDR_LEN-1:0] req_addr;
  logic                resp_valid;
  logic [DATA_LEN-1:0] resp_data;

  modport master (output req_valid, req_addr, input req_ready, resp_valid, resp_data);
  modport slave  (input req_valid, req_addr, output req_ready, resp_valid, resp_data);
endinterface

interface ysyx_23060236_icache_mem_if #(
  parameter int ADDR_LEN = ysyx_23060236_icache_sa_pkg::ADDR_LEN_DEF,
  parameter int DATA_LEN = ysyx_23060236_icache_sa_pkg::DATA_LEN_DEF
);
  logic                mem_arvalid;
  logic                mem_arready;
  logic [ADDR_LEN-1:0] mem_araddr;
  logic [7:0]          mem_arlen;
  logic                mem_rvalid;
  logic [DATA_LEN-1:0] mem_rdata;
  logic                mem_rlast;
  logic                mem_rready;

  modport master (output mem_arvalid, mem_araddr, mem_arlen, mem_rready,
                  input  mem_arready, mem_rvalid, mem_rdata, mem_rlast);
  modport slave  (input  mem_arvalid, mem_araddr, mem_arlen, mem_rready,
                  output mem_arready, mem_rvalid, mem_rdata, mem_rlast);
endinterface

// File: rtl/ysyx_23060236_icache_sa_way.sv
// One cache way: per-set tag, valid bit and line data, with a combinational
// lookup port, a beat-granular data write port and a bulk invalidate.
module ysyx_23060236_icache_way #(
  parameter int TAG_LEN   = 18,
  parameter int INDEX_LEN = 2,
  parameter int WORD_BITS = 3,
  parameter int DATA_LEN  = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [INDEX_LEN-1:0] rd_index_i,
  input  logic [TAG_LEN-1:0]   rd_tag_i,
  input  logic [WORD_BITS-1:0] rd_word_i,
  output logic                 valid_o,
  output logic                 hit_o,
  output logic [DATA_LEN-1:0]  rdata_o,
  input  logic                 we_data_i,
  input  logic                 we_tag_i,
  input  logic [INDEX_LEN-1:0] wr_index_i,
  input  logic [WORD_BITS-1:0] wr_word_i,
  input  logic [DATA_LEN-1:0]  wr_data_i,
  input  logic [TAG_LEN-1:0]   wr_tag_i,
  input  logic                 clr_i
);
  localparam int SETS       = 1 << INDEX_LEN;
  localparam int LINE_WORDS = 1 << WORD_BITS;

  logic [SETS-1:0]     valid_q;
  logic [TAG_LEN-1:0]  tag_q  [SETS];
  logic [DATA_LEN-1:0] data_q [SETS][LINE_WORDS];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (clr_i) begin
      valid_q <= '0;
    end else if (we_tag_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays carry no reset so they can map onto plain RAM;
  // the valid bits alone make their contents meaningful.
  always_ff @(posedge clock) begin
    if (we_data_i) data_q[wr_index_i][wr_word_i] <= wr_data_i;
    if (we_tag_i)  tag_q[wr_index_i] <= wr_tag_i;
  end

  assign valid_o = valid_q[rd_index_i];
  assign hit_o   = valid_o && (tag_q[rd_index_i] == rd_tag_i);
  assign rdata_o = data_q[rd_index_i][rd_word_i];

endmodule

// File: rtl/ysyx_23060236_icache_sa.sv
// Set-associative instruction cache with a line-refill burst engine,
// round-robin replacement and FENCE.I invalidation.
module ysyx_23060236_icache_sa
  import ysyx_23060236_icache_sa_pkg::*;
#(
  parameter int ADDR_LEN   = ADDR_LEN_DEF,
  parameter int DATA_LEN   = DATA_LEN_DEF,
  parameter int OFFSET_LEN = OFFSET_LEN_DEF,
  parameter int INDEX_LEN  = INDEX_LEN_DEF,
  parameter int WAYS       = WAYS_DEF
) (
  input  logic                        clock,
  input  logic                        reset,
  ysyx_23060236_icache_fetch_if.slave fetch,
  ysyx_23060236_icache_mem_if.master  mem,
  input  logic                        fence_i,
  output logic                        busy
);
  localparam int TAG_LEN   = ADDR_LEN - OFFSET_LEN - INDEX_LEN;
  localparam int LINE_LEN  = ADDR_LEN - OFFSET_LEN;
  localparam int WORD_BITS = OFFSET_LEN - 2;
  localparam int LWORDS    = line_words(OFFSET_LEN);
  localparam int SETS      = 1 << INDEX_LEN;
  localparam int WB        = way_bits(WAYS);

  state_e                        state_q, state_d;
  logic [LINE_LEN-1:0]           line_q, line_d;
  logic [WORD_BITS-1:0]          word_q, word_d, beat_q, beat_d;
  logic [WB-1:0]                 victim_q, victim_d, victim_sel;
  logic [SETS-1:0][WB-1:0]       rr_q, rr_d;
  logic                          fence_pend_q, fence_pend_d;
  logic                          resp_valid_q, resp_valid_d;
  logic [DATA_LEN-1:0]           resp_data_q, resp_data_d, hit_data;
  logic                          hit_any, victim_found, req_ready, clr, beat_fire;
  logic [WAYS-1:0]               way_valid, way_hit;
  logic [WAYS-1:0][DATA_LEN-1:0] way_rdata;

  logic [TAG_LEN-1:0]   req_tag;
  logic [INDEX_LEN-1:0] req_index, line_index;
  logic [WORD_BITS-1:0] req_word;
  logic                 unused_byte_bits;

  assign req_tag          = fetch.req_addr[ADDR_LEN-1 -: TAG_LEN];
  assign req_index        = fetch.req_addr[OFFSET_LEN +: INDEX_LEN];
  assign req_word         = fetch.req_addr[2 +: WORD_BITS];
  assign unused_byte_bits = ^fetch.req_addr[1:0];
  assign line_index       = line_q[INDEX_LEN-1:0];
  assign beat_fire        = (state_q == S_R) && mem.mem_rvalid;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    ysyx_23060236_icache_way #(
      .TAG_LEN(TAG_LEN), .INDEX_LEN(INDEX_LEN), .WORD_BITS(WORD_BITS), .DATA_LEN(DATA_LEN)
    ) u_way (
      .clock      (clock),
      .reset      (reset),
      .rd_index_i (req_index),
      .rd_tag_i   (req_tag),
      .rd_word_i  (req_word),
      .valid_o    (way_valid[w]),
      .hit_o      (way_hit[w]),
      .rdata_o    (way_rdata[w]),
      .we_data_i  (beat_fire && (victim_q == WB'(w))),
      .we_tag_i   (beat_fire && mem.mem_rlast && (victim_q == WB'(w))),
      .wr_index_i (line_index),
      .wr_word_i  (beat_q),
      .wr_data_i  (mem.mem_rdata),
      .wr_tag_i   (line_q[LINE_LEN-1:INDEX_LEN]),
      .clr_i      (clr)
    );
  end

  // One-hot hit mux plus victim pick: lowest invalid way, else round-robin.
  always_comb begin
    hit_any      = 1'b0;
    hit_data     = '0;
    victim_found = 1'b0;
    victim_sel   = rr_q[req_index];
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) begin
        hit_any  = 1'b1;
        hit_data = hit_data | way_rdata[w];
      end
      if (!victim_found && !way_valid[w]) begin
        victim_found = 1'b1;
        victim_sel   = WB'(w);
      end
    end
  end

  // NOTE: every always_comb output gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    word_d       = word_q;
    victim_d     = victim_q;
    beat_d       = beat_q;
    rr_d         = rr_q;
    fence_pend_d = fence_pend_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    req_ready    = 1'b0;
    clr          = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        clr          = fence_i || fence_pend_q;
        fence_pend_d = 1'b0;
        req_ready    = !clr;
        if (fetch.req_valid && req_ready) begin
          if (hit_any) begin
            resp_valid_d = 1'b1;
            resp_data_d  = hit_data;
          end else begin
            line_d   = fetch.req_addr[ADDR_LEN-1:OFFSET_LEN];
            word_d   = req_word;
            victim_d = victim_sel;
            state_d  = S_AR;
          end
        end
      end
      S_AR: begin
        if (mem.mem_arready) begin
          beat_d  = '0;
          state_d = S_R;
        end
      end
      S_R: begin
        if (mem.mem_rvalid) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == word_q) resp_data_d = mem.mem_rdata;
          if (mem.mem_rlast) begin
            rr_d[line_index] = (rr_q[line_index] == WB'(WAYS - 1)) ? '0 : rr_q[line_index] + 1'b1;
            resp_valid_d     = 1'b1;
            state_d          = S_RESP;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && fence_i) fence_pend_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      line_q       <= '0;
      word_q       <= '0;
      victim_q     <= '0;
      beat_q       <= '0;
      rr_q         <= '0;
      fence_pend_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      word_q       <= word_d;
      victim_q     <= victim_d;
      beat_q       <= beat_d;
      rr_q         <= rr_d;
      fence_pend_q <= fence_pend_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign fetch.req_ready  = req_ready;
  assign fetch.resp_valid = resp_valid_q;
  assign fetch.resp_data  = resp_data_q;
  assign mem.mem_arvalid  = (state_q == S_AR);
  assign mem.mem_araddr   = {line_q, {OFFSET_LEN{1'b0}}};
  assign mem.mem_arlen    = 8'(LWORDS - 1);
  assign mem.mem_rready   = (state_q == S_R);
  assign busy             = (state_q != S_IDLE) || fence_pend_q;

endmodule

// File: tb/tb_ysyx_23060236_icache_sa.sv
// Directed bench for the set-associative icache: the bench plays the IFU and
// the burst memory, and checks each step against hand-computed values.
module tb_ysyx_23060236_icache_sa;

  logic clock   = 1'b0;
  logic reset   = 1'b1;
  logic fence_i = 1'b0;
  logic busy;
  int   total   = 0;
  int   bad     = 0;

  ysyx_23060236_icache_fetch_if fetch_bus ();
  ysyx_23060236_icache_mem_if   mem_bus ();

  ysyx_23060236_icache_sa dut (
    .clock   (clock),
    .reset   (reset),
    .fetch   (fetch_bus),
    .mem     (mem_bus),
    .fence_i (fence_i),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Full miss: accept, AR held one cycle before arready, eight beats, RESP.
  // A non-negative fence_beat raises fence_i during that beat.
  task automatic miss(input logic [24:0] addr, input logic [31:0] base, input int fence_beat);
    logic [24:0] line;
    logic [31:0] word;
    line = addr & ~25'h1F;
    word = 32'((addr >> 2) & 25'h7);
    fetch_bus.req_valid = 1'b1;
    fetch_bus.req_addr  = addr;
    #1 check("miss_req_ready", 32'(fetch_bus.req_ready), 1);
    tick();
    fetch_bus.req_valid = 1'b0;
    #1;
    check("miss_arvalid", 32'(mem_bus.mem_arvalid), 1);
    check("miss_araddr", 32'(mem_bus.mem_araddr), 32'(line));
    check("miss_arlen", 32'(mem_bus.mem_arlen), 7);
    check("miss_busy_ar", 32'(busy), 1);
    tick();
    check("miss_arvalid_held", 32'(mem_bus.mem_arvalid), 1);
    check("miss_rready_in_ar", 32'(mem_bus.mem_rready), 0);
    mem_bus.mem_arready = 1'b1;
    tick();
    mem_bus.mem_arready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_bus.mem_rvalid = 1'b1;
      mem_bus.mem_rdata  = base + 32'(i);
      mem_bus.mem_rlast  = (i == 7);
      fence_i            = (i == fence_beat);
      #1 check("miss_rready", 32'(mem_bus.mem_rready), 1);
      tick();
    end
    mem_bus.mem_rvalid = 1'b0;
    mem_bus.mem_rlast  = 1'b0;
    fence_i            = 1'b0;
    #1;
    check("miss_resp_valid", 32'(fetch_bus.resp_valid), 1);
    check("miss_resp_data", fetch_bus.resp_data, base + word);
    if (fence_beat >= 0) check("fence_busy_resp", 32'(busy), 1);
    tick();
    check("miss_resp_pulse_end", 32'(fetch_bus.resp_valid), 0);
    if (fence_beat >= 0) begin
      #1;
      check("fence_pend_ready", 32'(fetch_bus.req_ready), 0);
      check("fence_pend_busy", 32'(busy), 1);
      tick();
      check("fence_done_ready", 32'(fetch_bus.req_ready), 1);
      check("fence_done_busy", 32'(busy), 0);
    end
  endtask

  task automatic hit(input logic [24:0] addr, input logic [31:0] exp);
    fetch_bus.req_valid = 1'b1;
    fetch_bus.req_addr  = addr;
    #1 check("hit_req_ready", 32'(fetch_bus.req_ready), 1);
    tick();
    fetch_bus.req_valid = 1'b0;
    #1;
    check("hit_resp_valid", 32'(fetch_bus.resp_valid), 1);
    check("hit_resp_data", fetch_bus.resp_data, exp);
    check("hit_no_arvalid", 32'(mem_bus.mem_arvalid), 0);
    tick();
  endtask

  initial begin
    fetch_bus.req_valid = 1'b0;
    fetch_bus.req_addr  = '0;
    mem_bus.mem_arready = 1'b0;
    mem_bus.mem_rvalid  = 1'b0;
    mem_bus.mem_rdata   = '0;
    mem_bus.mem_rlast   = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_req_ready", 32'(fetch_bus.req_ready), 1);
    check("rst_resp_valid", 32'(fetch_bus.resp_valid), 0);
    check("rst_arvalid", 32'(mem_bus.mem_arvalid), 0);
    check("rst_rready", 32'(mem_bus.mem_rready), 0);
    check("rst_busy", 32'(busy), 0);
    @(negedge clock);

    // Cold miss mid-line, then back-to-back hits at both ends of the line.
    miss(25'h0000104, 32'hA0, -1);
    fetch_bus.req_valid = 1'b1;
    fetch_bus.req_addr  = 25'h0000100;
    #1 check("b2b_ready0", 32'(fetch_bus.req_ready), 1);
    tick();
    fetch_bus.req_addr = 25'h000011C;
    #1;
    check("b2b_valid0", 32'(fetch_bus.resp_valid), 1);
    check("b2b_data0", fetch_bus.resp_data, 32'hA0);
    check("b2b_noar0", 32'(mem_bus.mem_arvalid), 0);
    check("b2b_ready1", 32'(fetch_bus.req_ready), 1);
    tick();
    fetch_bus.req_valid = 1'b0;
    #1;
    check("b2b_valid1", 32'(fetch_bus.resp_valid), 1);
    check("b2b_data1", fetch_bus.resp_data, 32'hA7);
    check("b2b_noar1", 32'(mem_bus.mem_arvalid), 0);
    tick();
    check("b2b_idle", 32'(fetch_bus.resp_valid), 0);

    // Fresh cache, then three lines into set 0: the third evicts way 0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    miss(25'h0000000, 32'hB0, -1);
    miss(25'h0000080, 32'hC0, -1);
    miss(25'h0000100, 32'hD0, -1);
    hit(25'h0000080, 32'hC0);
    hit(25'h0000104, 32'hD1);
    miss(25'h0000000, 32'hE0, -1);

    // FENCE.I in IDLE beats a simultaneous request and drops set 1.
    miss(25'h0000020, 32'hF0, -1);
    hit(25'h0000024, 32'hF1);
    fence_i             = 1'b1;
    fetch_bus.req_valid = 1'b1;
    fetch_bus.req_addr  = 25'h0000020;
    #1 check("fence_idle_ready", 32'(fetch_bus.req_ready), 0);
    tick();
    fence_i             = 1'b0;
    fetch_bus.req_valid = 1'b0;
    #1;
    check("fence_idle_no_resp", 32'(fetch_bus.resp_valid), 0);
    check("fence_idle_no_ar", 32'(mem_bus.mem_arvalid), 0);
    check("fence_idle_busy", 32'(busy), 0);
    miss(25'h0000020, 32'h10, -1);

    // FENCE.I during refill: refill completes, then the line is dropped.
    miss(25'h0000048, 32'h30, 3);
    miss(25'h0000048, 32'h50, -1);

    // Reset in the middle of a burst, then the same line misses again.
    fetch_bus.req_valid = 1'b1;
    fetch_bus.req_addr  = 25'h0000060;
    tick();
    fetch_bus.req_valid = 1'b0;
    #1 check("abort_arvalid", 32'(mem_bus.mem_arvalid), 1);
    mem_bus.mem_arready = 1'b1;
    tick();
    mem_bus.mem_arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_bus.mem_rvalid = 1'b1;
      mem_bus.mem_rdata  = 32'h70 + 32'(i);
      tick();
    end
    #1 check("abort_rready_before", 32'(mem_bus.mem_rready), 1);
    #1 reset = 1'b1;
    #1;
    check("abort_rready", 32'(mem_bus.mem_rready), 0);
    check("abort_arvalid_rst", 32'(mem_bus.mem_arvalid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_resp_valid", 32'(fetch_bus.resp_valid), 0);
    mem_bus.mem_rvalid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    miss(25'h0000060, 32'h80, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_23060236_icache_sa.md
Name: ysyx_23060236_icache_sa

Overview:
Parametrised set-associative instruction cache with its own refill engine. It sits between IFU fetch and the SDRAM-side burst read port. It handles hits internally and fills a whole line per miss with one INCR burst. It adds FENCE.I invalidation and round-robin replacement, and generalises sets, ways and line size.

Parameters:
ADDR_LEN, 25, physical fetch address width (matches SDRAM range)
DATA_LEN, 32, instruction word width
OFFSET_LEN, 5, byte-offset bits per line (line = 2**(OFFSET_LEN-2) words)
INDEX_LEN, 2, set-index bits (2**INDEX_LEN sets)
WAYS, 2, associativity, power of two, 1..8

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  fetch request
req_addr  in  ADDR_LEN  fetch address, word aligned
req_ready  out  1  request accepted when req_valid&req_ready
resp_valid  out  1  one-cycle pulse, resp_data valid
resp_data  out  DATA_LEN  fetched word
fence_i  in  1  invalidate all lines
busy  out  1  FSM not in IDLE or fence pending
mem_arvalid  out  1  burst request
mem_arready  in  1  burst accepted
mem_araddr  out  ADDR_LEN  line-aligned address (low OFFSET_LEN bits zero)
mem_arlen  out  8  constant 2**(OFFSET_LEN-2)-1
mem_rvalid  in  1  beat valid
mem_rdata  in  DATA_LEN  beat data
mem_rlast  in  1  final beat
mem_rready  out  1  beat accepted

Behaviour:
- Address split: tag = [ADDR_LEN-1:OFFSET_LEN+INDEX_LEN], index = [OFFSET_LEN+INDEX_LEN-1:OFFSET_LEN], word = [OFFSET_LEN-1:2].
- Reset (async): state=IDLE; all valid bits=0; round-robin pointers=0; resp_valid, mem_arvalid, mem_rready, busy = 0. Tags and data are not reset. An outstanding burst is abandoned, and the memory side is reset with the core.
- FSM states:
  - IDLE: req_ready=1 unless fence_i or a pending fence. On accept, do a combinational lookup across all ways of the set.
    - Hit: data registered; resp_valid=1 next cycle; stay IDLE. Back-to-back hits give 1 word/cycle.
    - Miss: latch addr, set and victim; go AR.
  - AR: mem_arvalid=1, mem_araddr=line base. On mem_arready go R. arvalid stays held until accepted.
  - R: mem_rready=1. Each beat writes data[set][victim][beat_cnt]; beat_cnt increments and wraps at line size. The beat whose count equals the requested word is captured for the response. On rvalid&rlast: write tag, set valid, advance the set's round-robin pointer, go RESP.
  - RESP: resp_valid=1 for one cycle with the captured word; go IDLE.
- Miss latency: response arrives exactly 1 cycle after the rlast beat.
- Victim choice: lowest-index invalid way, else the set's round-robin pointer (mod WAYS). With WAYS=1 this degenerates to direct-mapped.
- rlast arriving before the expected beat count is a protocol error. The line is installed anyway, and unreceived words are undefined.
- Hit ignores a way being refilled, because requests are not accepted outside IDLE.
- fence_i:
  - In IDLE: all valid bits clear on the next edge, and req_ready=0 that cycle.
  - Outside IDLE: a pending flag is set. The in-flight refill completes and responds, then all valid bits clear in the first IDLE cycle, before any new accept.
  - busy stays high while the fence is pending.
- fence_i together with req_valid in IDLE: the fence wins and the request is not accepted.
- resp has no backpressure; the consumer must take the pulse.

Decomposition:
- Shared package: address-field width constants, LINE_WORDS = 2**(OFFSET_LEN-2), WAY_BITS = clog2(WAYS), and the state encoding (IDLE, AR, R, RESP).
- Sub-module ysyx_23060236_icache_way:
  - Holds one way's tag/data arrays and valid vector.
  - Provides a combinational hit/rdata output per set, plus a write port and a clear.
  - The top instantiates it WAYS times and adds a one-hot hit mux.

Test Plan:
- Cold miss at 0x0000104 (set 0): mem_araddr=0x0000100, arlen=7. Eight beats return 0xA0..0xA7, and resp_data=0xA1 arrives 1 cycle after rlast.
- Then requests to 0x0000100, 0x000011C on consecutive cycles: no mem_arvalid, resp 0xA0 and 0xA7 on consecutive cycles.
- WAYS=2: misses at 0x0000000, 0x0000080, 0x0000100 (all set 0). The third evicts way 0 (round-robin), so 0x0000080 still hits and 0x0000000 misses.
- fence_i in IDLE after filling set 1 (0x0000020): req_ready=0 that cycle, and the next access to 0x0000020 misses.
- fence_i asserted during R state: the refill completes with a correct resp, busy holds, and a subsequent request to the same line misses.
- Assert reset after beat 3 of a refill: outputs drop asynchronously to 0. After reset release, a request to the same line misses and issues a fresh AR.
